// File: rtl/toggle_period_checker.sv
// Receive-side checker for a free-running toggle: measures half-periods, locks, flags early/late edges.
// Optional TOGGLE_CHK_STICKY_EN: locked-state errors park the FSM in FAULT until clr_err.
module toggle_period_checker #(
    parameter int unsigned EXP_HALF   = 8,
    parameter int unsigned TOL        = 0,
    parameter int unsigned LOCK_EDGES = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] last_half,
    output logic [CNT_W-1:0] edge_cnt
);
    localparam logic [CNT_W-1:0] Lo    = CNT_W'(EXP_HALF - TOL);
    localparam logic [CNT_W-1:0] Hi    = CNT_W'(EXP_HALF + TOL);
    localparam int unsigned      GoodW = $clog2(LOCK_EDGES + 1);
    localparam logic [GoodW-1:0] LockGood = GoodW'(LOCK_EDGES);

    typedef enum logic [2:0] {StIdle, StSeek, StTrain, StLocked, StFault} state_e;

    state_e           state_q;
    logic             in_q;
    logic [CNT_W-1:0] timer_q;
    logic [GoodW-1:0] good_q;

    logic             edge_det;
    logic             in_win;
    logic             overdue;
    logic             err_evt;
    logic [CNT_W-1:0] timer_inc;
    logic [GoodW-1:0] good_inc;

    always_comb begin
        edge_det  = in ^ in_q;
        in_win    = (timer_q >= Lo) && (timer_q <= Hi);
        // Fires on the cycle the timer would step past hi, so a locked edge never sees interval > hi.
        overdue   = !edge_det && (timer_q >= Hi);
        timer_inc = (&timer_q) ? timer_q : timer_q + CNT_W'(1);
        good_inc  = good_q + GoodW'(1);
        err_evt   = en && (state_q == StLocked) && (edge_det ? !in_win : overdue);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            in_q      <= 1'b0;
            timer_q   <= '0;
            good_q    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            last_half <= '0;
            edge_cnt  <= '0;
        end else begin
            in_q      <= in;
            err_pulse <= err_evt;

            if (en && edge_det) begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end

            if (clr_err) begin
                err_cnt <= err_evt ? ERR_W'(1) : '0;
            end else if (err_evt && !(&err_cnt)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end

            if (!en) begin
                state_q <= StIdle;
                timer_q <= '0;
                good_q  <= '0;
                locked  <= 1'b0;
            end else begin
                timer_q <= edge_det ? CNT_W'(1) : timer_inc;
                case (state_q)
                    StIdle: begin
                        state_q <= StSeek;
                        timer_q <= '0;
                        good_q  <= '0;
                    end
                    StSeek: begin
                        if (edge_det) begin
                            state_q <= StTrain;
                        end
                    end
                    StTrain: begin
                        if (edge_det) begin
                            last_half <= timer_q;
                            if (in_win) begin
                                good_q <= good_inc;
                                if (good_inc == LockGood) begin
                                    state_q <= StLocked;
                                    locked  <= 1'b1;
                                end
                            end else begin
                                good_q <= '0;
                            end
                        end else if (overdue) begin
                            state_q <= StSeek;
                            good_q  <= '0;
                        end
                    end
                    StLocked: begin
                        if (edge_det) begin
                            last_half <= timer_q;
                        end
                        if (err_evt) begin
                            locked <= 1'b0;
                            good_q <= '0;
`ifdef TOGGLE_CHK_STICKY_EN
                            state_q <= StFault;
`else
                            state_q <= edge_det ? StTrain : StSeek;
`endif
                        end
                    end
`ifdef TOGGLE_CHK_STICKY_EN
                    StFault: begin
                        if (clr_err) begin
                            state_q <= StSeek;
                            good_q  <= '0;
                        end
                    end
`endif
                    default: begin
                        state_q <= StIdle;
                        locked  <= 1'b0;
                        good_q  <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_toggle_period_checker.sv
// Directed bench for toggle_period_checker with EXP_HALF=5, TOL=0, LOCK_EDGES=2, ERR_W=2.
module tb_toggle_period_checker;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned ERR_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             tog;
    logic             clr_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [CNT_W-1:0] last_half;
    logic [CNT_W-1:0] edge_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    toggle_period_checker #(
        .EXP_HALF  (5),
        .TOL       (0),
        .LOCK_EDGES(2),
        .CNT_W     (CNT_W),
        .ERR_W     (ERR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in       (tog),
        .clr_err  (clr_err),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .last_half(last_half),
        .edge_cnt (edge_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle();
        tog = ~tog;
    endtask

    // From locked and on cadence: one good edge, then an edge 3 cycles later.
    task automatic do_early(input logic clr);
        toggle(); step(3);
        toggle(); clr_err = clr; step(1);
        clr_err = 1'b0;
    endtask

    // From TRAIN right after an early error: two good intervals back to lock, on cadence.
    task automatic relock_from_train(input int pre);
        step(pre);
        toggle(); step(5);
        toggle(); step(5);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; tog = 1'b0; clr_err = 1'b0;
        step(2);
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b want 0", locked); end
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %0b want 0", err_pulse); end
        n_tests++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
        n_tests++; if (last_half !== 16'd0) begin n_fail++; $display("FAIL reset_last: got %0d want 0", last_half); end
        n_tests++; if (edge_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_edges: got %0d want 0", edge_cnt); end
    endtask

    task automatic test_lock();
        rst = 1'b0; en = 1'b1;
        step(1);
        toggle(); step(5);
        toggle(); step(5);
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %0b want 0", locked); end
        toggle(); step(1);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked: got %0b want 1", locked); end
        n_tests++; if (last_half !== 16'd5) begin n_fail++; $display("FAIL lock_last: got %0d want 5", last_half); end
        n_tests++; if (edge_cnt !== 16'd3) begin n_fail++; $display("FAIL lock_edges: got %0d want 3", edge_cnt); end
        n_tests++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL lock_errcnt: got %0d want 0", err_cnt); end
        step(4);
    endtask

    task automatic test_early();
        do_early(1'b0);
        n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL early_pulse: got %0b want 1", err_pulse); end
        n_tests++; if (err_cnt !== 2'd1) begin n_fail++; $display("FAIL early_errcnt: got %0d want 1", err_cnt); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL early_unlock: got %0b want 0", locked); end
        n_tests++; if (last_half !== 16'd3) begin n_fail++; $display("FAIL early_last: got %0d want 3", last_half); end
        step(1);
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL early_pulse_width: got %0b want 0", err_pulse); end
        step(3);
        toggle(); step(5);
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL early_relock_soon: got %0b want 0", locked); end
        toggle(); step(1);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL early_relock: got %0b want 1", locked); end
        step(4);
    endtask

    task automatic test_stuck();
        step(1);
        n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL stuck_pulse: got %0b want 1", err_pulse); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL stuck_unlock: got %0b want 0", locked); end
        n_tests++; if (err_cnt !== 2'd2) begin n_fail++; $display("FAIL stuck_errcnt: got %0d want 2", err_cnt); end
        step(1);
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL stuck_pulse_width: got %0b want 0", err_pulse); end
        toggle(); step(5);
        toggle(); step(5);
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL stuck_relock_soon: got %0b want 0", locked); end
        toggle(); step(1);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL stuck_relock: got %0b want 1", locked); end
        step(4);
    endtask

    task automatic test_saturate();
        logic [ERR_W-1:0] exp_cnt;
        toggle(); clr_err = 1'b1; step(1);
        clr_err = 1'b0;
        n_tests++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_clear: got %0d want 0", err_cnt); end
        step(4);
        for (int i = 1; i <= 5; i++) begin
            exp_cnt = (i >= 3) ? 2'd3 : ERR_W'(i);
            do_early(1'b0);
            n_tests++;
            if (err_cnt !== exp_cnt) begin
                n_fail++; $display("FAIL sat_errcnt_%0d: got %0d want %0d", i, err_cnt, exp_cnt);
            end
            relock_from_train(4);
        end
        do_early(1'b1);
        n_tests++; if (err_cnt !== 2'd1) begin n_fail++; $display("FAIL sat_clr_with_err: got %0d want 1", err_cnt); end
        n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_clr_pulse: got %0b want 1", err_pulse); end
        relock_from_train(4);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_relock: got %0b want 1", locked); end
    endtask

    task automatic test_rst_en();
        #2 rst = 1'b1;
        #1;
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL arst_locked: got %0b want 0", locked); end
        n_tests++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL arst_errcnt: got %0d want 0", err_cnt); end
        n_tests++; if (edge_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_edges: got %0d want 0", edge_cnt); end
        n_tests++; if (last_half !== 16'd0) begin n_fail++; $display("FAIL arst_last: got %0d want 0", last_half); end
        tog = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);
        toggle(); step(5);
        toggle(); step(5);
        toggle(); step(5);
        do_early(1'b0);
        relock_from_train(4);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL en_prelock: got %0b want 1", locked); end
        en = 1'b0;
        step(1);
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL en_unlock: got %0b want 0", locked); end
        n_tests++; if (err_cnt !== 2'd1) begin n_fail++; $display("FAIL en_errcnt_hold: got %0d want 1", err_cnt); end
        n_tests++; if (edge_cnt !== 16'd7) begin n_fail++; $display("FAIL en_edges_hold: got %0d want 7", edge_cnt); end
        n_tests++; if (last_half !== 16'd5) begin n_fail++; $display("FAIL en_last_hold: got %0d want 5", last_half); end
        toggle(); step(2);
        n_tests++; if (edge_cnt !== 16'd7) begin n_fail++; $display("FAIL en_edges_off: got %0d want 7", edge_cnt); end
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL en_no_err: got %0b want 0", err_pulse); end
    endtask

    task automatic test_sticky();
        do_early(1'b0);
        n_tests++; if (err_cnt !== 2'd1) begin n_fail++; $display("FAIL sticky_errcnt: got %0d want 1", err_cnt); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL sticky_unlock: got %0b want 0", locked); end
        toggle(); step(2);
        toggle(); step(2);
        n_tests++; if (err_cnt !== 2'd1) begin n_fail++; $display("FAIL sticky_hold: got %0d want 1", err_cnt); end
        n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL sticky_pulse: got %0b want 0", err_pulse); end
        clr_err = 1'b1; step(1);
        clr_err = 1'b0;
        n_tests++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL sticky_clear: got %0d want 0", err_cnt); end
        step(1);
        toggle(); step(5);
        toggle(); step(5);
        toggle(); step(1);
        n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sticky_relock: got %0b want 1", locked); end
    endtask

    initial begin
        test_reset();
        test_lock();
`ifdef TOGGLE_CHK_STICKY_EN
        test_sticky();
`else
        test_early();
        test_stuck();
        test_saturate();
        test_rst_en();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/toggle_period_checker.md
Name: toggle_period_checker

Overview:
- Receive-side monitor for the free-running 1-bit toggle output of the counter block.
- Samples the toggle on the same clock and measures the cycle count between consecutive edges (half-periods).
- Locks once the measured half-period matches the programmed value.
- After lock, reports early, late or stuck toggles as errors with a saturating error counter.
- Sits next to the counter in the same clock domain and serves as a self-checking end of that output.

Parameters:
EXP_HALF, 8, expected half-period in clock cycles (>=2)
TOL, 0, allowed deviation in cycles; must satisfy TOL < EXP_HALF-1
LOCK_EDGES, 2, consecutive good intervals required to lock (>=1)
CNT_W, 16, width of timer, LAST_HALF and EDGE_CNT
ERR_W, 8, width of ERR_CNT

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
EN  in  1  checker enable; 0 forces IDLE
IN  in  1  toggle signal under test (counter OUT)
CLR_ERR  in  1  single-cycle clear of ERR_CNT (and FAULT, see optional feature)
LOCKED  out  1  checker is locked to the toggle
ERR_PULSE  out  1  one-cycle pulse per detected error
ERR_CNT  out  ERR_W  saturating error count
LAST_HALF  out  CNT_W  most recent measured interval
EDGE_CNT  out  CNT_W  edges seen while EN=1, wraps modulo 2^CNT_W

Behaviour:
Reset (RST=1, asynchronous):
- in_q=0, timer=0, good=0, state=IDLE.
- All outputs 0.

Edge detection and timing:
- in_q <= IN every cycle; edge = IN ^ in_q.
- All outputs are registered: effects appear the cycle after the edge is sampled.
- On an edge, interval = timer; then timer <= 1.
- Otherwise timer increments, saturating at all-ones.
- Window: lo = EXP_HALF-TOL, hi = EXP_HALF+TOL.

Counters:
- EDGE_CNT increments on every edge with EN=1.
- LAST_HALF updates on every edge in TRAIN or LOCKED.

States:
- IDLE: LOCKED=0, timer=0, good=0. When EN=1, go to SEEK.
- SEEK: on the first edge, timer <= 1 and go to TRAIN. No errors are reported in this state.
- TRAIN:
  - Edge with interval in [lo,hi]: good++. When good reaches LOCK_EDGES, go to LOCKED and set LOCKED=1.
  - Edge with interval outside the window: good <= 0; stay in TRAIN.
  - timer > hi without an edge: go to SEEK with good=0.
  - No errors are reported in this state.
- LOCKED:
  - Edge with interval in [lo,hi]: stay in LOCKED.
  - Edge with interval < lo: early error. ERR_PULSE fires, LOCKED=0, good=0, go to TRAIN.
  - timer reaches hi+1 without an edge: late/stuck error. ERR_PULSE fires, LOCKED=0, go to SEEK.
- At most one error per cycle.

Error counter:
- ERR_CNT saturates at 2^ERR_W-1.
- CLR_ERR sets ERR_CNT to 0.
- If CLR_ERR and an error occur in the same cycle, ERR_CNT becomes 1.

Enable:
- EN=0 in any state goes to IDLE next cycle.
- ERR_CNT, EDGE_CNT and LAST_HALF hold their values.
- RST mid-operation clears everything immediately.

Optional Feature:
Macro TOGGLE_CHK_STICKY_EN.
- Defined:
  - Any LOCKED-state error moves the FSM to state FAULT.
  - In FAULT: LOCKED=0, edges are ignored for checking, and no further ERR_PULSE or ERR_CNT increments occur.
  - CLR_ERR in FAULT clears ERR_CNT and goes to SEEK.
  - EN=0 still forces IDLE, but ERR_CNT is held.
- Not defined: no FAULT state; after an error the FSM re-acquires automatically as described above.

Test Plan:
Settings for all scenarios: EXP_HALF=5, TOL=0, LOCK_EDGES=2.
1. Release RST, EN=1, IN toggles every 5 cycles -> LOCKED=1 one cycle after the 3rd edge; LAST_HALF=5; ERR_CNT=0; EDGE_CNT=3 at lock.
2. Locked, then one interval of 3 cycles -> ERR_PULSE high for exactly 1 cycle; ERR_CNT=1; LOCKED=0; relock after 2 more 5-cycle intervals.
3. Locked, then IN held constant -> ERR_PULSE when timer reaches 6; state SEEK; LOCKED=0; relock needs 1 edge plus 2 good intervals.
4. ERR_W=2, five forced errors -> ERR_CNT=3 (saturated). CLR_ERR on the same cycle as an error -> ERR_CNT=1.
5. RST asserted mid-LOCKED, between clock edges -> all outputs 0 immediately. EN dropped while locked -> IDLE next cycle, LOCKED=0, ERR_CNT held.
6. TOGGLE_CHK_STICKY_EN build: early toggle while locked -> ERR_CNT=1; further bad toggles leave ERR_CNT=1; CLR_ERR -> ERR_CNT=0, SEEK, relock as in test 1.
